// File: rtl/quad_encoder_position_pkg.sv
// -----------------------------------------------------------------------------
// quad_encoder_position_pkg
//   Shared constants and types for the quadrature encoder decoder.
//   - Gray-code A/B state constants ({A,B} bit order)
//   - decoder FSM state type
//   - default position width / counts-per-rev shared with the PWM generator
//   - helper returning the next A/B state in the forward direction
// -----------------------------------------------------------------------------
package quad_encoder_position_pkg;

   localparam int DEFAULT_WIDTH = 10;
   localparam int DEFAULT_PPR   = 1024;

   localparam logic [1:0] AB_00 = 2'b00;
   localparam logic [1:0] AB_01 = 2'b01;
   localparam logic [1:0] AB_11 = 2'b11;
   localparam logic [1:0] AB_10 = 2'b10;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_TRACK = 1'b1
   } dec_state_t;

   // Forward sequence is 00 -> 01 -> 11 -> 10 -> 00.
   function automatic logic [1:0] gray_fwd(input logic [1:0] ab);
      logic [1:0] nxt;
      case (ab)
         AB_00:   nxt = AB_01;
         AB_01:   nxt = AB_11;
         AB_11:   nxt = AB_10;
         default: nxt = AB_00;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/quad_encoder_position_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_position_if
//   Bundles the encoder pins, control requests and decoded outputs.
//   master : drives encoder pins and requests, observes outputs (stimulus side)
//   slave  : the decoder; receives pins and requests, drives outputs
//   Signals:
//     enc_a, enc_b, enc_z  encoder channels (asynchronous to CLK)
//     zero_req, err_clr    synchronous control requests
//     Position [WIDTH]     wrapped count 0..PPR-1
//     dir, step, err, index_seen  status outputs
// -----------------------------------------------------------------------------
interface quad_encoder_position_if
   import quad_encoder_position_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             enc_a;
   logic             enc_b;
   logic             enc_z;
   logic             zero_req;
   logic             err_clr;
   logic [WIDTH-1:0] Position;
   logic             dir;
   logic             step;
   logic             err;
   logic             index_seen;

   modport master (
      output enc_a, enc_b, enc_z, zero_req, err_clr,
      input  Position, dir, step, err, index_seen
   );

   modport slave (
      input  enc_a, enc_b, enc_z, zero_req, err_clr,
      output Position, dir, step, err, index_seen
   );

endinterface

// File: rtl/quad_encoder_position_enc_sync_filter.sv
// -----------------------------------------------------------------------------
// enc_sync_filter
//   2-FF synchronizer followed by a stability filter for one encoder pin.
//   The filtered output follows the synchronized input only after the two
//   have differed for FILT consecutive samples; shorter pulses are dropped.
//   Ports:
//     CLK, reset_n  clock / asynchronous active-low reset
//     din           raw pin, asynchronous to CLK
//     dout          filtered level
//     primed        high once dout holds a genuine pin sample
// -----------------------------------------------------------------------------
module enc_sync_filter #(
   parameter int FILT = 3
) (
   input  logic CLK,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic primed
);

   localparam int             CW       = (FILT < 2) ? 1 : $clog2(FILT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic [1:0]    valid_reg;
   logic [CW-1:0] cnt_reg;
   logic          dout_reg;
   logic          primed_reg;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         valid_reg  <= 2'b00;
         cnt_reg    <= '0;
         dout_reg   <= 1'b0;
         primed_reg <= 1'b0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
         valid_reg <= {valid_reg[0], 1'b1};

         if (!primed_reg) begin
            // The first real sample is adopted directly, so a pin that is
            // already high at reset release is not mistaken for an edge.
            cnt_reg <= '0;
            if (valid_reg[1]) begin
               dout_reg   <= sync2_reg;
               primed_reg <= 1'b1;
            end
         end else if (sync2_reg == dout_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            dout_reg <= sync2_reg;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign dout   = dout_reg;
   assign primed = primed_reg;

endmodule

// File: rtl/quad_encoder_position.sv
// -----------------------------------------------------------------------------
// quad_encoder_position
//   4x quadrature decoder producing a mod-PPR position count for the PWM
//   generator, plus direction, per-count step strobe, sticky illegal-transition
//   flag and sticky index-seen flag.
//   Ports:
//     CLK      system clock (posedge)
//     reset_n  asynchronous active-low reset
//     bus      slave side of quad_encoder_position_if (pins, requests, outputs)
//   Parameters: WIDTH, PPR (2..2**WIDTH), FILT (>=1), INDEX_EN (1 = Z clears).
// -----------------------------------------------------------------------------
module quad_encoder_position
   import quad_encoder_position_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int PPR      = DEFAULT_PPR,
   parameter int FILT     = 3,
   parameter int INDEX_EN = 1
) (
   input  logic                   CLK,
   input  logic                   reset_n,
   quad_encoder_position_if.slave bus
);

   localparam logic [WIDTH-1:0] POS_LAST = WIDTH'(PPR - 1);

   // Bit 2 = Z, bit 1 = A, bit 0 = B, so filt_vec[1:0] is {A,B}.
   logic [2:0] pin_vec;
   logic [2:0] filt_vec;
   logic [2:0] primed_vec;

   assign pin_vec = {bus.enc_z, bus.enc_a, bus.enc_b};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_in
         enc_sync_filter #(
            .FILT (FILT)
         ) u_filt (
            .CLK     (CLK),
            .reset_n (reset_n),
            .din     (pin_vec[gi]),
            .dout    (filt_vec[gi]),
            .primed  (primed_vec[gi])
         );
      end
   endgenerate

   dec_state_t       state_reg;
   logic [1:0]       prev_ab_reg;
   logic             z_prev_reg;
   logic [WIDTH-1:0] position_reg;
   logic             dir_reg;
   logic             step_reg;
   logic             err_reg;
   logic             index_seen_reg;

   logic [1:0]       cur_ab;
   logic             is_fwd;
   logic             is_rev;
   logic             is_bad;
   logic             z_rise;
   logic [WIDTH-1:0] pos_inc;
   logic [WIDTH-1:0] pos_dec;

   always_comb begin
      cur_ab  = filt_vec[1:0];
      is_fwd  = (cur_ab == gray_fwd(prev_ab_reg));
      is_rev  = (prev_ab_reg == gray_fwd(cur_ab));
      is_bad  = ((prev_ab_reg ^ cur_ab) == 2'b11);
      z_rise  = filt_vec[2] & ~z_prev_reg;
      // Wrap at PPR rather than at 2**WIDTH.
      pos_inc = (position_reg == POS_LAST) ? '0 : position_reg + WIDTH'(1);
      pos_dec = (position_reg == '0) ? POS_LAST : position_reg - WIDTH'(1);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_INIT;
         prev_ab_reg    <= AB_00;
         z_prev_reg     <= 1'b0;
         position_reg   <= '0;
         dir_reg        <= 1'b0;
         step_reg       <= 1'b0;
         err_reg        <= 1'b0;
         index_seen_reg <= 1'b0;
      end else begin
         step_reg <= 1'b0;
         // A fault detected below overrides this clear in the same cycle.
         if (bus.err_clr) begin
            err_reg <= 1'b0;
         end

         case (state_reg)
            ST_INIT: begin
               if (bus.zero_req) begin
                  position_reg <= '0;
               end
               // Wait until every filter carries a real pin sample, then take
               // it as the reference without counting or flagging.
               if (&primed_vec) begin
                  prev_ab_reg <= cur_ab;
                  z_prev_reg  <= filt_vec[2];
                  state_reg   <= ST_TRACK;
               end
            end

            ST_TRACK: begin
               prev_ab_reg <= cur_ab;
               z_prev_reg  <= filt_vec[2];

               // Direction tracks every valid count, even a discarded one.
               if (is_fwd) begin
                  dir_reg <= 1'b1;
               end else if (is_rev) begin
                  dir_reg <= 1'b0;
               end

               if (is_bad) begin
                  err_reg <= 1'b1;
               end

               if (z_rise) begin
                  index_seen_reg <= 1'b1;
               end

               if (bus.zero_req) begin
                  position_reg <= '0;
               end else if (z_rise && (INDEX_EN != 0)) begin
                  position_reg <= '0;
               end else if (is_fwd) begin
                  position_reg <= pos_inc;
                  step_reg     <= 1'b1;
               end else if (is_rev) begin
                  position_reg <= pos_dec;
                  step_reg     <= 1'b1;
               end
            end

            default: state_reg <= ST_INIT;
         endcase
      end
   end

   assign bus.Position   = position_reg;
   assign bus.dir        = dir_reg;
   assign bus.step       = step_reg;
   assign bus.err        = err_reg;
   assign bus.index_seen = index_seen_reg;

endmodule

// File: tb/tb_quad_encoder_position.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_position
//   Directed stimulus for quad_encoder_position (WIDTH=10, PPR=1024, FILT=3,
//   INDEX_EN=1) with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_quad_encoder_position;
   import quad_encoder_position_pkg::*;

   localparam int WIDTH = 10;
   localparam int PPR   = 1024;
   localparam int FILT  = 3;

   logic       CLK = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] ab = 2'b00;
   int         total = 0;
   int         bad = 0;
   int         step_cnt = 0;
   int         base = 0;

   quad_encoder_position_if #(.WIDTH(WIDTH)) bus ();

   quad_encoder_position #(
      .WIDTH    (WIDTH),
      .PPR      (PPR),
      .FILT     (FILT),
      .INDEX_EN (1)
   ) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (bus.step === 1'b1) step_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drive_ab(input logic [1:0] v);
      ab = v;
      bus.enc_a = v[1];
      bus.enc_b = v[0];
   endtask

   function automatic logic [1:0] next_fwd(input logic [1:0] v);
      case (v)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] next_rev(input logic [1:0] v);
      case (v)
         2'b00:   return 2'b10;
         2'b10:   return 2'b11;
         2'b11:   return 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic fwd(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive_ab(next_fwd(ab));
         tick(gap);
      end
   endtask

   task automatic rev(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive_ab(next_rev(ab));
         tick(gap);
      end
   endtask

   initial begin
      bus.enc_a    = 1'b0;
      bus.enc_b    = 1'b0;
      bus.enc_z    = 1'b0;
      bus.zero_req = 1'b0;
      bus.err_clr  = 1'b0;
      reset_n      = 1'b0;
      tick(3);

      // Reset state
      check("rst_pos",   32'(bus.Position), 0);
      check("rst_dir",   32'(bus.dir), 0);
      check("rst_step",  32'(bus.step), 0);
      check("rst_err",   32'(bus.err), 0);
      check("rst_index", 32'(bus.index_seen), 0);
      reset_n = 1'b1;
      tick(10);
      check("post_rst_pos", 32'(bus.Position), 0);

      // 1: eight forward steps
      base = step_cnt;
      fwd(8, 20);
      check("t1_pos",   32'(bus.Position), 8);
      check("t1_dir",   32'(bus.dir), 1);
      check("t1_steps", 32'(step_cnt - base), 8);
      check("t1_err",   32'(bus.err), 0);

      // 2: wrap around zero in both directions
      bus.zero_req = 1'b1;
      tick(1);
      bus.zero_req = 1'b0;
      check("t2_zero", 32'(bus.Position), 0);
      tick(2);
      fwd(1, 20);
      check("t2_pos1", 32'(bus.Position), 1);
      rev(1, 20);
      check("t2_rev0", 32'(bus.Position), 0);
      rev(1, 20);
      check("t2_rev1023", 32'(bus.Position), 1023);
      rev(1, 20);
      check("t2_rev1022", 32'(bus.Position), 1022);
      check("t2_dir_rev", 32'(bus.dir), 0);
      fwd(1, 20);
      check("t2_fwd1023", 32'(bus.Position), 1023);
      fwd(1, 20);
      check("t2_fwd0", 32'(bus.Position), 0);
      check("t2_dir_fwd", 32'(bus.dir), 1);

      // 3: glitch rejection, then exact latency of an accepted edge
      base = step_cnt;
      bus.enc_a = 1'b1;
      tick(2);
      bus.enc_a = 1'b0;
      tick(20);
      check("t3_glitch_pos",   32'(bus.Position), 0);
      check("t3_glitch_steps", 32'(step_cnt - base), 0);
      drive_ab(2'b10);
      tick(5);
      check("t3_lat5_pos", 32'(bus.Position), 0);
      check("t3_lat5_step", 32'(bus.step), 0);
      tick(1);
      check("t3_lat6_pos", 32'(bus.Position), 1023);
      check("t3_lat6_step", 32'(bus.step), 1);
      check("t3_lat6_dir", 32'(bus.dir), 0);
      tick(1);
      check("t3_step_1cyc", 32'(bus.step), 0);
      tick(20);
      fwd(1, 20);
      check("t3_back0", 32'(bus.Position), 0);

      // 4: illegal transition and err_clr interaction
      base = step_cnt;
      drive_ab(2'b11);
      tick(20);
      check("t4_err_set",  32'(bus.err), 1);
      check("t4_pos_hold", 32'(bus.Position), 0);
      check("t4_no_step",  32'(step_cnt - base), 0);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      check("t4_err_clr", 32'(bus.err), 0);
      drive_ab(2'b00);
      tick(5);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      check("t4_set_wins", 32'(bus.err), 1);
      tick(5);
      check("t4_sticky", 32'(bus.err), 1);
      check("t4_pos_hold2", 32'(bus.Position), 0);

      // 5: index handling and zero request
      check("t5_index_pre", 32'(bus.index_seen), 0);
      fwd(500, 8);
      check("t5_pos500", 32'(bus.Position), 500);
      bus.enc_z = 1'b1;
      tick(5);
      bus.enc_z = 1'b0;
      tick(20);
      check("t5_index_pos", 32'(bus.Position), 0);
      check("t5_index_seen", 32'(bus.index_seen), 1);
      rev(3, 20);
      check("t5_rev_pos", 32'(bus.Position), 1021);
      check("t5_rev_dir", 32'(bus.dir), 0);
      base = step_cnt;
      bus.enc_z = 1'b1;
      drive_ab(next_fwd(ab));
      tick(6);
      check("t5_coinc_pos", 32'(bus.Position), 0);
      check("t5_coinc_dir", 32'(bus.dir), 1);
      bus.enc_z = 1'b0;
      tick(20);
      check("t5_coinc_steps", 32'(step_cnt - base), 0);
      check("t5_coinc_hold", 32'(bus.Position), 0);
      fwd(37, 8);
      check("t5_pos37", 32'(bus.Position), 37);
      bus.zero_req = 1'b1;
      tick(1);
      bus.zero_req = 1'b0;
      check("t5_zero_req", 32'(bus.Position), 0);
      tick(20);

      // 6: async reset mid-motion with A=B=1
      fwd(3, 20);
      check("t6_pos3", 32'(bus.Position), 3);
      check("t6_ab11", 32'(ab), 3);
      reset_n = 1'b0;
      #1;
      check("t6_rst_pos",   32'(bus.Position), 0);
      check("t6_rst_dir",   32'(bus.dir), 0);
      check("t6_rst_step",  32'(bus.step), 0);
      check("t6_rst_err",   32'(bus.err), 0);
      check("t6_rst_index", 32'(bus.index_seen), 0);
      tick(1);
      reset_n = 1'b1;
      base = step_cnt;
      tick(20);
      check("t6_rel_pos",   32'(bus.Position), 0);
      check("t6_rel_err",   32'(bus.err), 0);
      check("t6_rel_steps", 32'(step_cnt - base), 0);
      drive_ab(2'b10);
      tick(20);
      check("t6_step_pos", 32'(bus.Position), 1);
      check("t6_step_dir", 32'(bus.dir), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
